csr_file: RTL and testbench

- Machine-mode CSR register file for core0; the responder end of the interrupt controller's CSR write port.
- Accepts sequenced trap/mret writes from the interrupt controller (cl_*) and csrrw/csrrs/csrrc results from EX (ex_*).
- Serves a combinational read port to ID.
- Exports live mstatus/mtvec/mepc to the interrupt controller, and mip/mie state for interrupt gating.

---
 rtl/csr_file_pkg.sv | 40 ++++
 rtl/csr_file_if.sv | 24 ++
 rtl/csr_file_counter64.sv | 33 +++
 rtl/csr_file.sv | 128 ++++++++++++
 tb/tb_csr_file.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/csr_file_pkg.sv
// rtl/csr_file_pkg.sv - CSR addresses, write masks and mstatus bit positions
package csr_file_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  localparam logic [31:0] MSTATUS_WMASK = (32'd1 << MSTATUS_MIE_BIT) | (32'd1 << MSTATUS_MPIE_BIT);
  localparam logic [31:0] MSTATUS_FIXED = 32'h0000_1800;
  localparam logic [31:0] MIE_WMASK     = 32'h0000_0080;
  localparam logic [31:0] XVEC_WMASK    = 32'hFFFF_FFFC;

  // Value a write to addr would leave in the register (also the bypass value).
  function automatic logic [31:0] csr_wmask(input logic [11:0] addr, input logic [31:0] data);
    case (addr)
      CSR_MSTATUS:         return (data & MSTATUS_WMASK) | MSTATUS_FIXED;
      CSR_MIE:             return data & MIE_WMASK;
      CSR_MTVEC, CSR_MEPC: return data & XVEC_WMASK;
      default:             return data;
    endcase
  endfunction

  function automatic logic csr_plain_rw(input logic [11:0] addr);
    return (addr == CSR_MSTATUS) || (addr == CSR_MIE) || (addr == CSR_MTVEC) ||
           (addr == CSR_MSCRATCH) || (addr == CSR_MEPC) || (addr == CSR_MCAUSE);
  endfunction

endpackage

// File: rtl/csr_file_if.sv
// rtl/csr_file_if.sv - CSR read port and the two CSR write ports (EX and interrupt controller)
interface csr_if;
  logic [11:0] id_csr_raddr_i;
  logic [31:0] id_csr_rdata_o;
  logic        id_csr_illegal_o;
  logic        ex_csr_we_i;
  logic [11:0] ex_csr_waddr_i;
  logic [31:0] ex_csr_wdata_i;
  logic        cl_csr_we_i;
  logic [11:0] cl_csr_waddr_i;
  logic [31:0] cl_csr_wdata_i;

  modport master (
    output id_csr_raddr_i, ex_csr_we_i, ex_csr_waddr_i, ex_csr_wdata_i,
           cl_csr_we_i, cl_csr_waddr_i, cl_csr_wdata_i,
    input  id_csr_rdata_o, id_csr_illegal_o
  );

  modport slave (
    input  id_csr_raddr_i, ex_csr_we_i, ex_csr_waddr_i, ex_csr_wdata_i,
           cl_csr_we_i, cl_csr_waddr_i, cl_csr_wdata_i,
    output id_csr_rdata_o, id_csr_illegal_o
  );
endinterface

// File: rtl/csr_file_counter64.sv
// rtl/csr_file_counter64.sv - 64-bit wrapping counter with independent half writes
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        we_lo,
  input  logic [31:0] wdata_lo,
  input  logic        we_hi,
  input  logic [31:0] wdata_hi,
  output logic [63:0] value
);

  logic [31:0] lo_q;
  logic [31:0] hi_q;
  logic        carry;

  assign carry = inc && (lo_q == 32'hFFFF_FFFF);
  assign value = {hi_q, lo_q};

  // A written low half suppresses the carry into the high half that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      if (we_lo)    lo_q <= wdata_lo;
      else if (inc) lo_q <= lo_q + 32'd1;
      if (we_hi)                hi_q <= wdata_hi;
      else if (carry && !we_lo) hi_q <= hi_q + 32'd1;
    end
  end

endmodule

// File: rtl/csr_file.sv
// rtl/csr_file.sv - core0 machine-mode CSR file; counters built only with CSR_COUNTERS_EN
module csr_file
  import csr_file_pkg::*;
#(
  parameter logic [31:0] HART_ID   = 32'd0,
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        timer_int_i,
  input  logic        instret_i,
  csr_if.slave        bus,
  output logic [31:0] mstatus_o,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic [31:0] mie_o,
  output logic [31:0] mip_o
);

  logic [11:0] raddr, ex_waddr, cl_waddr;
  logic        ex_we, cl_we;
  logic [31:0] ex_wdata, cl_wdata;

  assign raddr    = bus.id_csr_raddr_i;
  assign ex_we    = bus.ex_csr_we_i;
  assign ex_waddr = bus.ex_csr_waddr_i;
  assign ex_wdata = bus.ex_csr_wdata_i;
  assign cl_we    = bus.cl_csr_we_i;
  assign cl_waddr = bus.cl_csr_waddr_i;
  assign cl_wdata = bus.cl_csr_wdata_i;

  // The EX data is only picked when the controller is not writing the same address.
  function automatic logic wr_hit(input logic [11:0] a);
    return (cl_we && cl_waddr == a) || (ex_we && ex_waddr == a);
  endfunction

  function automatic logic [31:0] wr_val(input logic [11:0] a);
    return csr_wmask(a, (cl_we && cl_waddr == a) ? cl_wdata : ex_wdata);
  endfunction

  logic [31:0] mstatus_q, mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_q  <= MSTATUS_FIXED;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RST & XVEC_WMASK;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      if (wr_hit(CSR_MSTATUS))  mstatus_q  <= wr_val(CSR_MSTATUS);
      if (wr_hit(CSR_MIE))      mie_q      <= wr_val(CSR_MIE);
      if (wr_hit(CSR_MTVEC))    mtvec_q    <= wr_val(CSR_MTVEC);
      if (wr_hit(CSR_MSCRATCH)) mscratch_q <= wr_val(CSR_MSCRATCH);
      if (wr_hit(CSR_MEPC))     mepc_q     <= wr_val(CSR_MEPC);
      if (wr_hit(CSR_MCAUSE))   mcause_q   <= wr_val(CSR_MCAUSE);
    end
  end

  assign mstatus_o = mstatus_q;
  assign mtvec_o   = mtvec_q;
  assign mepc_o    = mepc_q;
  assign mie_o     = mie_q;
  assign mip_o     = {24'b0, timer_int_i, 7'b0};

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle, minstret;

  csr_counter64 u_mcycle (
    .clk      (clk),
    .rst      (rst),
    .inc      (1'b1),
    .we_lo    (wr_hit(CSR_MCYCLE)),
    .wdata_lo (wr_val(CSR_MCYCLE)),
    .we_hi    (wr_hit(CSR_MCYCLEH)),
    .wdata_hi (wr_val(CSR_MCYCLEH)),
    .value    (mcycle)
  );

  csr_counter64 u_minstret (
    .clk      (clk),
    .rst      (rst),
    .inc      (instret_i),
    .we_lo    (wr_hit(CSR_MINSTRET)),
    .wdata_lo (wr_val(CSR_MINSTRET)),
    .we_hi    (wr_hit(CSR_MINSTRETH)),
    .wdata_hi (wr_val(CSR_MINSTRETH)),
    .value    (minstret)
  );
`else
  logic unused_instret;
  assign unused_instret = instret_i;
`endif

  logic [31:0] reg_val;
  logic        implemented;
  logic        rd_writable;

  always_comb begin
    reg_val     = '0;
    implemented = 1'b1;
    rd_writable = csr_plain_rw(raddr);
    case (raddr)
      CSR_MSTATUS:  reg_val = mstatus_q;
      CSR_MIE:      reg_val = mie_q;
      CSR_MTVEC:    reg_val = mtvec_q;
      CSR_MSCRATCH: reg_val = mscratch_q;
      CSR_MEPC:     reg_val = mepc_q;
      CSR_MCAUSE:   reg_val = mcause_q;
      CSR_MIP:      reg_val = mip_o;
      CSR_MHARTID:  reg_val = HART_ID;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:    begin reg_val = mcycle[31:0];    rd_writable = 1'b1; end
      CSR_MCYCLEH:   begin reg_val = mcycle[63:32];   rd_writable = 1'b1; end
      CSR_MINSTRET:  begin reg_val = minstret[31:0];  rd_writable = 1'b1; end
      CSR_MINSTRETH: begin reg_val = minstret[63:32]; rd_writable = 1'b1; end
`else
      CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH: reg_val = '0;
`endif
      default:      implemented = 1'b0;
    endcase
  end

  assign bus.id_csr_rdata_o   = (rd_writable && wr_hit(raddr)) ? wr_val(raddr) : reg_val;
  assign bus.id_csr_illegal_o = !implemented;

endmodule

// File: tb/tb_csr_file.sv
// tb/tb_csr_file.sv - randomized and directed bench for csr_file against a behavioural CSR model
module tb_csr_file;

  localparam logic [31:0] HART       = 32'd5;
  localparam logic [31:0] MTVEC_INIT = 32'h0000_1003;
`ifdef CSR_COUNTERS_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, timer, instret;
  logic [31:0] mstatus, mtvec, mepc, mie, mip;

  csr_if bus();

  csr_file #(.HART_ID(HART), .MTVEC_RST(MTVEC_INIT)) dut (
    .clk         (clk),
    .rst         (rst),
    .timer_int_i (timer),
    .instret_i   (instret),
    .bus         (bus.slave),
    .mstatus_o   (mstatus),
    .mtvec_o     (mtvec),
    .mepc_o      (mepc),
    .mie_o       (mie),
    .mip_o       (mip)
  );

  always #50 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Behavioural model: plain registers keyed by address, counters as 64-bit integers.
  bit [31:0]       mdl_reg [bit [11:0]];
  longint unsigned cyc, ret;

  bit [11:0] addr_pool [14] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344,
                                12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14, 12'h7C0, 12'h301};

  task automatic mdl_reset();
    mdl_reg.delete();
    mdl_reg[12'h300] = 32'h0000_1800;
    mdl_reg[12'h304] = 32'h0;
    mdl_reg[12'h305] = MTVEC_INIT & 32'hFFFF_FFFC;
    mdl_reg[12'h340] = 32'h0;
    mdl_reg[12'h341] = 32'h0;
    mdl_reg[12'h342] = 32'h0;
    cyc = 0;
    ret = 0;
  endtask

  function automatic bit [31:0] mask(input bit [11:0] a, input bit [31:0] d);
    case (a)
      12'h300:          return (d & 32'h88) | 32'h1800;
      12'h304:          return d & 32'h80;
      12'h305, 12'h341: return d & 32'hFFFF_FFFC;
      default:          return d;
    endcase
  endfunction

  function automatic bit is_cnt(input bit [11:0] a);
    return a == 12'hB00 || a == 12'hB80 || a == 12'hB02 || a == 12'hB82;
  endfunction

  task automatic find_wr(input bit [11:0] a, output bit ok, output bit [31:0] d);
    ok = 1'b1;
    d  = '0;
    if (bus.cl_csr_we_i && bus.cl_csr_waddr_i == a)      d = bus.cl_csr_wdata_i;
    else if (bus.ex_csr_we_i && bus.ex_csr_waddr_i == a) d = bus.ex_csr_wdata_i;
    else ok = 1'b0;
  endtask

  task automatic mdl_read(input bit [11:0] a, output bit [31:0] d, output bit ill);
    bit ok;
    bit [31:0] wd;
    ill = 1'b0;
    find_wr(a, ok, wd);
    if (ok && (mdl_reg.exists(a) || (CNT_EN && is_cnt(a)))) d = mask(a, wd);
    else if (mdl_reg.exists(a)) d = mdl_reg[a];
    else if (a == 12'h344)      d = timer ? 32'h80 : 32'h0;
    else if (a == 12'hF14)      d = HART;
    else if (is_cnt(a)) begin
      if (!CNT_EN)            d = 32'h0;
      else if (a == 12'hB00)  d = cyc[31:0];
      else if (a == 12'hB80)  d = cyc[63:32];
      else if (a == 12'hB02)  d = ret[31:0];
      else                    d = ret[63:32];
    end else begin
      d   = 32'h0;
      ill = 1'b1;
    end
  endtask

  task automatic cnt_next(inout longint unsigned v, input bit inc, input bit [11:0] alo, input bit [11:0] ahi);
    bit ok_lo, ok_hi;
    bit [31:0] d_lo, d_hi;
    longint unsigned nv;
    bit [31:0] lo, hi;
    find_wr(alo, ok_lo, d_lo);
    find_wr(ahi, ok_hi, d_hi);
    nv = v + longint'(inc);
    lo = ok_lo ? d_lo : nv[31:0];
    hi = ok_hi ? d_hi : (ok_lo ? v[63:32] : nv[63:32]);
    v  = {hi, lo};
  endtask

  task automatic mdl_update();
    bit ok;
    bit [31:0] d;
    if (rst) begin
      mdl_reset();
    end else begin
      foreach (mdl_reg[k]) begin
        find_wr(k, ok, d);
        if (ok) mdl_reg[k] = mask(k, d);
      end
      cnt_next(cyc, 1'b1, 12'hB00, 12'hB80);
      cnt_next(ret, instret, 12'hB02, 12'hB82);
    end
  endtask

  task automatic idle();
    bus.ex_csr_we_i    = 1'b0;
    bus.ex_csr_waddr_i = '0;
    bus.ex_csr_wdata_i = '0;
    bus.cl_csr_we_i    = 1'b0;
    bus.cl_csr_waddr_i = '0;
    bus.cl_csr_wdata_i = '0;
    instret            = 1'b0;
  endtask

  task automatic step();
    bit [31:0] d;
    bit ill;
    @(negedge clk);
    mdl_read(bus.id_csr_raddr_i, d, ill);
    check("rdata", bus.id_csr_rdata_o, d);
    check("illegal", 32'(bus.id_csr_illegal_o), 32'(ill));
    check("mip_o", mip, timer ? 32'h80 : 32'h0);
    @(posedge clk);
    mdl_update();
    #1;
    check("mstatus_o", mstatus, mdl_reg[12'h300]);
    check("mtvec_o", mtvec, mdl_reg[12'h305]);
    check("mepc_o", mepc, mdl_reg[12'h341]);
    check("mie_o", mie, mdl_reg[12'h304]);
  endtask

  task automatic peek(input logic [11:0] a, input logic [31:0] exp_d, input logic exp_ill, input string tag);
    bus.id_csr_raddr_i = a;
    #1;
    check(tag, bus.id_csr_rdata_o, exp_d);
    check({tag, "_ill"}, 32'(bus.id_csr_illegal_o), 32'(exp_ill));
  endtask

  logic [11:0] rst_addr [13] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344,
                                 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14, 12'h7C0};
  logic [31:0] rst_exp  [13] = '{32'h1800, 32'h0, 32'h1000, 32'h0, 32'h0, 32'h0, 32'h0,
                                 32'h0, 32'h0, 32'h0, 32'h0, 32'd5, 32'h0};

  initial begin
    idle();
    timer = 1'b0;
    bus.id_csr_raddr_i = '0;
    rst = 1'b1;
    mdl_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (rst_addr[i]) peek(rst_addr[i], rst_exp[i], rst_addr[i] == 12'h7C0, "reset_read");
    check("reset_mstatus_o", mstatus, 32'h1800);
    check("reset_mtvec_o", mtvec, 32'h1000);

`ifdef CSR_COUNTERS_EN
    bus.cl_csr_we_i = 1'b1; bus.cl_csr_waddr_i = 12'hB00; bus.cl_csr_wdata_i = 32'hFFFF_FFFE;
    bus.ex_csr_we_i = 1'b1; bus.ex_csr_waddr_i = 12'hB80; bus.ex_csr_wdata_i = 32'h0;
    step();
    idle();
    step();
    step();
    peek(12'hB80, 32'h1, 1'b0, "mcycleh_carry");
    peek(12'hB00, 32'h0, 1'b0, "mcycle_wrap");
    instret = 1'b1;
    repeat (5) step();
    idle();
    peek(12'hB02, 32'd5, 1'b0, "minstret_5");
`endif

    bus.ex_csr_we_i = 1'b1; bus.ex_csr_waddr_i = 12'h300; bus.ex_csr_wdata_i = 32'hFFFF_FFFF;
    step();
    check("mstatus_all_ones", mstatus, 32'h0000_1888);
    bus.ex_csr_waddr_i = 12'h341; bus.ex_csr_wdata_i = 32'h8000_0123;
    step();
    check("mepc_align", mepc, 32'h8000_0120);

    bus.cl_csr_we_i = 1'b1; bus.cl_csr_waddr_i = 12'h341; bus.cl_csr_wdata_i = 32'h100;
    bus.ex_csr_we_i = 1'b1; bus.ex_csr_waddr_i = 12'h341; bus.ex_csr_wdata_i = 32'h200;
    peek(12'h341, 32'h100, 1'b0, "bypass_cl_wins");
    step();
    check("mepc_cl_wins", mepc, 32'h100);

    idle();
    bus.cl_csr_we_i = 1'b1; bus.cl_csr_waddr_i = 12'h341; bus.cl_csr_wdata_i = 32'h80;
    step();
    check("trap_mepc", mepc, 32'h80);
    bus.cl_csr_waddr_i = 12'h342; bus.cl_csr_wdata_i = 32'h8000_0007;
    step();
    bus.cl_csr_waddr_i = 12'h300; bus.cl_csr_wdata_i = 32'h0000_0080;
    peek(12'h342, 32'h8000_0007, 1'b0, "trap_mcause");
    step();
    check("trap_mstatus", mstatus, 32'h0000_1880);
    bus.cl_csr_wdata_i = 32'h0000_0088;
    step();
    check("mret_mie", 32'(mstatus[3]), 32'h1);

    idle();
    timer = 1'b1;
    bus.ex_csr_we_i = 1'b1; bus.ex_csr_waddr_i = 12'h344; bus.ex_csr_wdata_i = 32'hFFFF_FFFF;
    peek(12'h344, 32'h80, 1'b0, "mip_timer");
    check("mip_o_timer", mip, 32'h80);
    step();
    idle();
    peek(12'h344, 32'h80, 1'b0, "mip_after_write");
    timer = 1'b0;
    step();

    repeat (400) begin
      rst     = ($urandom_range(0, 49) == 0);
      timer   = 1'($urandom);
      instret = 1'($urandom);
      bus.cl_csr_we_i    = ($urandom_range(0, 2) == 0);
      bus.cl_csr_waddr_i = addr_pool[$urandom_range(0, 13)];
      bus.cl_csr_wdata_i = $urandom;
      bus.ex_csr_we_i    = 1'($urandom);
      bus.ex_csr_waddr_i = ($urandom_range(0, 3) == 0) ? bus.cl_csr_waddr_i : addr_pool[$urandom_range(0, 13)];
      bus.ex_csr_wdata_i = $urandom;
      case ($urandom_range(0, 3))
        0:       bus.id_csr_raddr_i = bus.cl_csr_waddr_i;
        1:       bus.id_csr_raddr_i = bus.ex_csr_waddr_i;
        default: bus.id_csr_raddr_i = addr_pool[$urandom_range(0, 13)];
      endcase
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
